// File: rtl/adc_stream_packer_pkg.sv
// rtl/adc_stream_packer_pkg.sv - shared types and pack format for the ADC stream packer
package adc_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        DRAIN,
        RELEASE
    } state_e;

    localparam int AXIS_W = 32;
    localparam int LANE_W = 16;

    // s0 (even sample) occupies the low lane, s1 the high lane
    function automatic logic [AXIS_W-1:0] pack_pair(input logic [LANE_W-1:0] s1,
                                                    input logic [LANE_W-1:0] s0);
        return {s1, s0};
    endfunction

endpackage

// File: rtl/adc_stream_packer_if.sv
// rtl/adc_stream_packer_if.sv - capture-block handshake, AXI-Stream output and status bundle
interface adc_stream_packer_if #(
    parameter int SAMPLE_W = 12
);
    logic                              i_Start;
    logic                              o_Busy;
    logic                              o_ADC_Work;
    logic                              i_ADC_Done;
    logic                              i_ADC_Last;
    logic [SAMPLE_W-1:0]               i_CMOS_Data;
    logic [adc_stream_pkg::AXIS_W-1:0] m_axis_tdata;
    logic                              m_axis_tvalid;
    logic                              m_axis_tready;
    logic                              m_axis_tlast;
    logic                              o_Overflow;
    logic                              o_Len_Err;
    logic [15:0]                       o_Frame_Count;

    modport master (
        input  i_Start, i_ADC_Done, i_ADC_Last, i_CMOS_Data, m_axis_tready,
        output o_Busy, o_ADC_Work, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               o_Overflow, o_Len_Err, o_Frame_Count
    );

    modport slave (
        output i_Start, i_ADC_Done, i_ADC_Last, i_CMOS_Data, m_axis_tready,
        input  o_Busy, o_ADC_Work, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
               o_Overflow, o_Len_Err, o_Frame_Count
    );
endinterface

// File: rtl/adc_stream_packer_sync_fifo.sv
// rtl/adc_stream_packer_sync_fifo.sv - first-word-fall-through FIFO, push accepted when full if popping
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop && !empty;
    // the slot being overwritten on a full push is the head being popped this cycle
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/adc_stream_packer.sv
// rtl/adc_stream_packer.sv - requests a capture frame, packs sample pairs into AXI-Stream words
module adc_stream_packer
    import adc_stream_pkg::*;
#(
    parameter int SAMPLE_W   = 12,
    parameter int FRAME_LEN  = 100000,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 20
) (
    input logic i_CMOS_Clk,
    input logic i_Reset,
    adc_stream_packer_if.master bus
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [SAMPLE_W-1:0] half_q, half_d;
    logic [AXIS_W:0]     pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic                ovf_q, ovf_d;
    logic                len_err_q, len_err_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                f_push, f_pop, f_full, f_empty;
    logic [AXIS_W:0]     f_wdata, f_rdata;
    logic                can_push;
    logic                at_end, is_final;
    logic                word_vld;
    logic [AXIS_W-1:0]   word;
    logic [LANE_W-1:0]   cur_ext, half_ext;

    assign cur_ext  = LANE_W'(bus.i_CMOS_Data);
    assign half_ext = LANE_W'(half_q);
    assign at_end   = (cnt_q == LAST_IDX);
    assign is_final = bus.i_ADC_Last || at_end;
    assign f_pop    = bus.m_axis_tready && !f_empty;
    assign can_push = !f_full || f_pop;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        half_d      = half_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        ovf_d       = ovf_q;
        len_err_d   = len_err_q;
        frame_cnt_d = frame_cnt_q;
        f_push      = 1'b0;
        f_wdata     = pend_q;
        word_vld    = 1'b0;
        word        = '0;

        case (state_q)
            IDLE: if (bus.i_Start) state_d = ARM;
            ARM: begin
                cnt_d   = '0;
                phase_d = 1'b0;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.i_ADC_Last != at_end) len_err_d = 1'b1;
                if (phase_q) begin
                    word_vld = 1'b1;
                    word     = pack_pair(cur_ext, half_ext);
                    phase_d  = 1'b0;
                end else if (is_final) begin
                    word_vld = 1'b1;
                    word     = pack_pair('0, cur_ext);
                end else begin
                    half_d  = bus.i_CMOS_Data;
                    phase_d = 1'b1;
                end
                // samples cannot be stalled: a full FIFO drops data words but parks the tlast word
                if (word_vld) begin
                    if (can_push) begin
                        f_push  = 1'b1;
                        f_wdata = {is_final, word};
                    end else if (is_final) begin
                        pend_d     = {1'b1, word};
                        pend_vld_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (is_final) state_d = DRAIN;
            end
            DRAIN: begin
                if (pend_vld_q) begin
                    if (can_push) begin
                        f_push     = 1'b1;
                        pend_vld_d = 1'b0;
                    end
                end else if (f_empty) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: if (!bus.i_ADC_Done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (f_pop && f_rdata[AXIS_W]) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge i_CMOS_Clk) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            half_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            ovf_q       <= ovf_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH(AXIS_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (i_CMOS_Clk),
        .rst  (i_Reset),
        .push (f_push),
        .wdata(f_wdata),
        .pop  (f_pop),
        .rdata(f_rdata),
        .full (f_full),
        .empty(f_empty)
    );

    assign bus.o_Busy        = (state_q != IDLE);
    assign bus.o_ADC_Work    = (state_q == ARM) || (state_q == CAPTURE) || (state_q == DRAIN);
    assign bus.m_axis_tvalid = !f_empty;
    assign bus.m_axis_tdata  = f_empty ? '0 : f_rdata[AXIS_W-1:0];
    assign bus.m_axis_tlast  = !f_empty && f_rdata[AXIS_W];
    assign bus.o_Overflow    = ovf_q;
    assign bus.o_Len_Err     = len_err_q;
    assign bus.o_Frame_Count = frame_cnt_q;
endmodule

// File: tb/tb_adc_stream_packer.sv
// tb/tb_adc_stream_packer.sv - directed bench over three packer configurations sharing one stimulus
module tb_adc_stream_packer;
    logic        clk = 1'b0;
    logic        rst, start, done, last, tready;
    logic [11:0] data;
    always #5 clk = ~clk;

    adc_stream_packer_if #(.SAMPLE_W(12)) if_a ();
    adc_stream_packer_if #(.SAMPLE_W(12)) if_b ();
    adc_stream_packer_if #(.SAMPLE_W(12)) if_c ();

    assign if_a.i_Start = start;  assign if_b.i_Start = start;  assign if_c.i_Start = start;
    assign if_a.i_ADC_Done = done;  assign if_b.i_ADC_Done = done;  assign if_c.i_ADC_Done = done;
    assign if_a.i_ADC_Last = last;  assign if_b.i_ADC_Last = last;  assign if_c.i_ADC_Last = last;
    assign if_a.i_CMOS_Data = data;  assign if_b.i_CMOS_Data = data;  assign if_c.i_CMOS_Data = data;
    assign if_a.m_axis_tready = tready;  assign if_b.m_axis_tready = tready;  assign if_c.m_axis_tready = tready;

    adc_stream_packer #(.SAMPLE_W(12), .FRAME_LEN(8), .FIFO_DEPTH(16), .CNT_W(20))
        dut_a (.i_CMOS_Clk(clk), .i_Reset(rst), .bus(if_a));
    adc_stream_packer #(.SAMPLE_W(12), .FRAME_LEN(7), .FIFO_DEPTH(16), .CNT_W(20))
        dut_b (.i_CMOS_Clk(clk), .i_Reset(rst), .bus(if_b));
    adc_stream_packer #(.SAMPLE_W(12), .FRAME_LEN(16), .FIFO_DEPTH(4), .CNT_W(20))
        dut_c (.i_CMOS_Clk(clk), .i_Reset(rst), .bus(if_c));

    int          sel;
    logic        busy, work, tvalid, tlast, ovf, lerr;
    logic [31:0] tdata;
    logic [15:0] fcnt;

    always_comb begin
        busy = if_a.o_Busy; work = if_a.o_ADC_Work; tvalid = if_a.m_axis_tvalid;
        tlast = if_a.m_axis_tlast; tdata = if_a.m_axis_tdata; ovf = if_a.o_Overflow;
        lerr = if_a.o_Len_Err; fcnt = if_a.o_Frame_Count;
        if (sel == 1) begin
            busy = if_b.o_Busy; work = if_b.o_ADC_Work; tvalid = if_b.m_axis_tvalid;
            tlast = if_b.m_axis_tlast; tdata = if_b.m_axis_tdata; ovf = if_b.o_Overflow;
            lerr = if_b.o_Len_Err; fcnt = if_b.o_Frame_Count;
        end else if (sel == 2) begin
            busy = if_c.o_Busy; work = if_c.o_ADC_Work; tvalid = if_c.m_axis_tvalid;
            tlast = if_c.m_axis_tlast; tdata = if_c.m_axis_tdata; ovf = if_c.o_Overflow;
            lerr = if_c.o_Len_Err; fcnt = if_c.o_Frame_Count;
        end
    end

    logic [32:0] got[$];
    logic [32:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(negedge clk) begin
        if (!rst && tvalid && tready) got.push_back({tlast, tdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; last = 1'b0; data = '0; tready = 1'b1; done = 1'b0;
        step();
        rst = 1'b0;
        got.delete();
    endtask

    // samples are base+1 .. base+n; Last on sample last_at (0 = never); start re-pulsed on sample start_at
    task automatic run_frame(input int n, input int last_at, input logic [11:0] base,
                             input int start_at, input string tag);
        logic [31:0] w0;
        w0 = {4'h0, base + 12'd2, 4'h0, base + 12'd1};
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({busy, work} !== 2'b11) begin
            n_bad++; $display("FAIL %s_arm: busy,work=%b want 11", tag, {busy, work});
        end
        step();
        for (int i = 1; i <= n; i++) begin
            data  = base + 12'(i);
            last  = (i == last_at);
            start = (i == start_at);
            step();
            if (i == 1) begin
                n_cmp++;
                if (tvalid !== 1'b0) begin
                    n_bad++; $display("FAIL %s_lat_even: tvalid=%b want 0", tag, tvalid);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if ({tvalid, tdata} !== {1'b1, w0}) begin
                    n_bad++; $display("FAIL %s_lat_odd: tvalid,tdata=%b,%h want 1,%h", tag, tvalid, tdata, w0);
                end
            end
        end
        data = '0; last = 1'b0; start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 40) begin
            step();
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_idle: busy=%b after %0d cycles want 0", tag, busy, k);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        do_reset();
        n_cmp++;
        if ({busy, work, tvalid, tlast, ovf, lerr} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: %b want 000000", {busy, work, tvalid, tlast, ovf, lerr});
        end
        n_cmp++;
        if (tdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_tdata: %h want 0", tdata);
        end
        n_cmp++;
        if (fcnt !== 16'h0) begin
            n_bad++; $display("FAIL reset_fcnt: %0d want 0", fcnt);
        end
    endtask

    task automatic test_basic();
        int k;
        sel = 0;
        do_reset();
        done = 1'b1;
        run_frame(8, 8, 12'h000, 0, "basic");
        k = 0;
        while (work && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if ({work, busy} !== 2'b01) begin
            n_bad++; $display("FAIL basic_release: work,busy=%b want 01", {work, busy});
        end
        n_cmp++;
        if (got.size() !== 4) begin
            n_bad++; $display("FAIL basic_beats_at_work_fall: %0d want 4", got.size());
        end
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_wait_done: busy=%b want 1", busy);
        end
        done = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_idle: busy=%b want 0", busy);
        end
        exp_q = '{33'h0_0002_0001, 33'h0_0004_0003, 33'h0_0006_0005, 33'h1_0008_0007};
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL basic_word%0d: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ({fcnt, lerr, ovf} !== {16'd1, 2'b00}) begin
            n_bad++; $display("FAIL basic_status: fcnt=%0d lerr=%b ovf=%b want 1,0,0", fcnt, lerr, ovf);
        end
    endtask

    task automatic test_odd_len();
        sel = 1;
        do_reset();
        run_frame(7, 7, 12'h0A0, 0, "odd");
        wait_idle("odd");
        exp_q = '{33'h0_00A2_00A1, 33'h0_00A4_00A3, 33'h0_00A6_00A5, 33'h1_0000_00A7};
        n_cmp++;
        if (got.size() !== 4) begin
            n_bad++; $display("FAIL odd_beats: %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL odd_word%0d: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ({fcnt, lerr} !== {16'd1, 1'b0}) begin
            n_bad++; $display("FAIL odd_status: fcnt=%0d lerr=%b want 1,0", fcnt, lerr);
        end
    endtask

    task automatic test_len_err();
        sel = 0;
        do_reset();
        run_frame(5, 5, 12'h000, 0, "early");
        wait_idle("early");
        exp_q = '{33'h0_0002_0001, 33'h0_0004_0003, 33'h1_0000_0005};
        n_cmp++;
        if (got.size() !== 3) begin
            n_bad++; $display("FAIL early_beats: %0d want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL early_word%0d: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ({fcnt, lerr} !== {16'd1, 1'b1}) begin
            n_bad++; $display("FAIL early_status: fcnt=%0d lerr=%b want 1,1", fcnt, lerr);
        end
        sel = 1;
        do_reset();
        run_frame(7, 0, 12'h0B0, 0, "nolast");
        wait_idle("nolast");
        n_cmp++;
        if (got.size() !== 4) begin
            n_bad++; $display("FAIL nolast_beats: %0d want 4", got.size());
        end
        n_cmp++;
        if (got.size() == 4 && got[3] !== 33'h1_0000_00B7) begin
            n_bad++; $display("FAIL nolast_tail: %h want 1000000b7", got[3]);
        end
        n_cmp++;
        if ({fcnt, lerr} !== {16'd1, 1'b1}) begin
            n_bad++; $display("FAIL nolast_status: fcnt=%0d lerr=%b want 1,1", fcnt, lerr);
        end
    endtask

    task automatic test_overflow();
        sel = 2;
        do_reset();
        tready = 1'b0;
        run_frame(16, 16, 12'h000, 0, "ovf");
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_bad++; $display("FAIL ovf_flag: %b want 1", ovf);
        end
        tready = 1'b1;
        wait_idle("ovf");
        exp_q = '{33'h0_0002_0001, 33'h0_0004_0003, 33'h0_0006_0005, 33'h0_0008_0007, 33'h1_0010_000F};
        n_cmp++;
        if (got.size() !== 5) begin
            n_bad++; $display("FAIL ovf_beats: %0d want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL ovf_word%0d: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_cmp++;
        if ({fcnt, lerr, ovf} !== {16'd1, 2'b01}) begin
            n_bad++; $display("FAIL ovf_status: fcnt=%0d lerr=%b ovf=%b want 1,0,1", fcnt, lerr, ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        do_reset();
        tready = 1'b0;
        start = 1'b1; step(); start = 1'b0; step();
        data = 12'h001; step();
        data = 12'h002; step();
        n_cmp++;
        if ({work, tvalid} !== 2'b11) begin
            n_bad++; $display("FAIL midrst_pre: work,tvalid=%b want 11", {work, tvalid});
        end
        data = 12'h003;
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++;
        if ({work, tvalid, busy, tlast} !== 4'b0 || tdata !== 32'h0) begin
            n_bad++; $display("FAIL midrst_post: work,tvalid,busy,tlast=%b tdata=%h want 0000,0",
                              {work, tvalid, busy, tlast}, tdata);
        end
        tready = 1'b1;
        got.delete();
        run_frame(8, 8, 12'h030, 0, "midrst");
        wait_idle("midrst");
        exp_q = '{33'h0_0032_0031, 33'h0_0034_0033, 33'h0_0036_0035, 33'h1_0038_0037};
        n_cmp++;
        if (got.size() !== 4) begin
            n_bad++; $display("FAIL midrst_beats: %0d want 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL midrst_word%0d: %h want %h", i, got[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (fcnt !== 16'd1) begin
            n_bad++; $display("FAIL midrst_fcnt: %0d want 1", fcnt);
        end
    endtask

    task automatic test_start_ignored();
        sel = 0;
        do_reset();
        tready = 1'b0;
        run_frame(8, 8, 12'h000, 4, "ign");
        start = 1'b1; step(); start = 1'b0; step();
        tready = 1'b1;
        wait_idle("ign");
        for (int k = 0; k < 6; k++) step();
        n_cmp++;
        if ({busy, tvalid} !== 2'b00) begin
            n_bad++; $display("FAIL ign_quiet: busy,tvalid=%b want 00", {busy, tvalid});
        end
        n_cmp++;
        if (got.size() !== 4 || fcnt !== 16'd1) begin
            n_bad++; $display("FAIL ign_frames: beats=%0d fcnt=%0d want 4,1", got.size(), fcnt);
        end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_basic();
        test_odd_len();
        test_len_err();
        test_overflow();
        test_reset_mid_frame();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
